// File: rtl/inter_slave_rx.sv
// Slave-side receiver: delayed ready, one write per handshake into an 8x3 regfile.
// Optional feature: define INTER_SLAVE_ACCUM_EN to accumulate (mod 8) instead of overwrite.
module inter_slave_rx #(
    parameter int unsigned READY_DELAY = 2,
    parameter int unsigned CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid,
    input  logic [2:0]       addr_in,
    input  logic [2:0]       value_in,
    output logic             ready,
    input  logic [2:0]       rd_addr,
    output logic [2:0]       rd_data,
    output logic [CNT_W-1:0] wr_count,
    output logic             busy
);

    typedef enum logic [1:0] {StIdle, StWait, StRdy, StCool} state_e;

    localparam logic [3:0] CNT_INIT = (READY_DELAY > 0) ? 4'(READY_DELAY - 1) : 4'd0;

    state_e     state;
    logic [3:0] cnt;
    logic [2:0] regs [8];
    logic [2:0] wr_val;

`ifdef INTER_SLAVE_ACCUM_EN
    assign wr_val = regs[addr_in] + value_in;
`else
    assign wr_val = value_in;
`endif

    assign rd_data = regs[rd_addr];

    // ready and busy are registered alongside the state so they change on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= StIdle;
            cnt      <= 4'd0;
            ready    <= 1'b0;
            busy     <= 1'b0;
            wr_count <= '0;
            for (int i = 0; i < 8; i++) begin
                regs[i] <= 3'd0;
            end
        end else begin
            case (state)
                StIdle: begin
                    if (valid) begin
                        busy <= 1'b1;
                        if (READY_DELAY == 0) begin
                            state <= StRdy;
                            ready <= 1'b1;
                        end else begin
                            state <= StWait;
                            cnt   <= CNT_INIT;
                        end
                    end
                end
                StWait: begin
                    if (!valid) begin
                        state <= StIdle;
                        busy  <= 1'b0;
                    end else if (cnt == 4'd0) begin
                        state <= StRdy;
                        ready <= 1'b1;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                StRdy: begin
                    ready <= 1'b0;
                    if (valid) begin
                        regs[addr_in] <= wr_val;
                        wr_count      <= wr_count + CNT_W'(1);
                        state         <= StCool;
                    end else begin
                        state <= StIdle;
                        busy  <= 1'b0;
                    end
                end
                StCool: begin
                    // Interconnect still holds valid this cycle; ignore it.
                    state <= StIdle;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= StIdle;
                    ready <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inter_slave_rx.sv
// Directed bench: one instance with READY_DELAY=2, one with READY_DELAY=0.
module tb_inter_slave_rx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       valid, valid0;
    logic [2:0] addr_in, value_in, rd_addr;
    logic       ready, busy, ready0, busy0;
    logic [2:0] rd_data, rd_data0;
    logic [7:0] wr_count, wr_count0;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    inter_slave_rx #(.READY_DELAY(2), .CNT_W(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .valid    (valid),
        .addr_in  (addr_in),
        .value_in (value_in),
        .ready    (ready),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .wr_count (wr_count),
        .busy     (busy)
    );

    inter_slave_rx #(.READY_DELAY(0), .CNT_W(8)) dut0 (
        .clk      (clk),
        .rst_n    (rst_n),
        .valid    (valid0),
        .addr_in  (addr_in),
        .value_in (value_in),
        .ready    (ready0),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data0),
        .wr_count (wr_count0),
        .busy     (busy0)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic peek(input logic [2:0] a, output logic [2:0] d, output logic [2:0] d0);
        rd_addr = a;
        #1;
        d  = rd_data;
        d0 = rd_data0;
    endtask

    logic [2:0] d, d0;
    logic [2:0] exp_acc, exp_wrap;
    bit         got;

    initial begin
        rst_n = 1'b0; valid = 1'b0; valid0 = 1'b0;
        addr_in = 3'd0; value_in = 3'd0; rd_addr = 3'd0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset then idle
        for (int i = 0; i < 10; i++) begin
            step();
            rd_addr = 3'(i);
            #1;
            check("idle_ready", 32'(ready), 32'd0);
            check("idle_busy", 32'(busy), 32'd0);
            check("idle_rd_data", 32'(rd_data), 32'd0);
        end
        check("idle_wr_count", 32'(wr_count), 32'd0);
        check("idle_wr_count0", 32'(wr_count0), 32'd0);

        // Single write, delay 2: addr 5 value 3
        valid = 1'b1; addr_in = 3'd5; value_in = 3'd3; rd_addr = 3'd5;
        step(); // E0
        check("sw_e0_ready", 32'(ready), 32'd0);
        check("sw_e0_busy", 32'(busy), 32'd1);
        step(); // E1
        check("sw_e1_ready", 32'(ready), 32'd0);
        step(); // E2
        check("sw_e2_ready", 32'(ready), 32'd1);
        check("sw_e2_old_data", 32'(rd_data), 32'd0);
        step(); // E3 accepts
        check("sw_e3_ready", 32'(ready), 32'd0);
        check("sw_e3_busy", 32'(busy), 32'd1);
        check("sw_e3_rd_data", 32'(rd_data), 32'd3);
        check("sw_e3_wr_count", 32'(wr_count), 32'd1);
        step(); // E4: handshake cycle, valid still high
        check("sw_e4_busy", 32'(busy), 32'd0);
        check("sw_e4_wr_count", 32'(wr_count), 32'd1);
        valid = 1'b0;
        step();
        check("nodbl_busy", 32'(busy), 32'd0);
        check("nodbl_wr_count", 32'(wr_count), 32'd1);

        // Withdraw during WAIT
        valid = 1'b1; addr_in = 3'd6; value_in = 3'd7; rd_addr = 3'd6;
        step(); // E0
        check("wd_e0_busy", 32'(busy), 32'd1);
        valid = 1'b0;
        step(); // E1
        check("wd_e1_busy", 32'(busy), 32'd0);
        check("wd_e1_ready", 32'(ready), 32'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            check("wd_ready", 32'(ready), 32'd0);
        end
        check("wd_rd_data", 32'(rd_data), 32'd0);
        check("wd_wr_count", 32'(wr_count), 32'd1);

        // Back-to-back, delay 0
        valid0 = 1'b1; addr_in = 3'd1; value_in = 3'd7;
        step();
        check("b2b_a_ready", 32'(ready0), 32'd1);
        step();
        check("b2b_a_ready_fall", 32'(ready0), 32'd0);
        check("b2b_a_count", 32'(wr_count0), 32'd1);
        step(); // handshake cycle
        valid0 = 1'b0;
        step(); // idle gap
        check("b2b_gap_busy", 32'(busy0), 32'd0);
        valid0 = 1'b1; addr_in = 3'd2; value_in = 3'd4;
        step();
        check("b2b_b_ready", 32'(ready0), 32'd1);
        step();
        step();
        valid0 = 1'b0;
        step();
        peek(3'd1, d, d0);
        check("b2b_reg1", 32'(d0), 32'd7);
        peek(3'd2, d, d0);
        check("b2b_reg2", 32'(d0), 32'd4);
        check("b2b_wr_count", 32'(wr_count0), 32'd2);
        check("b2b_other_dut_count", 32'(wr_count), 32'd1);

        // Two writes to addr 0 on delay-2 instance: 5 then 6
        for (int w = 0; w < 2; w++) begin
            valid = 1'b1; addr_in = 3'd0; value_in = (w == 0) ? 3'd5 : 3'd6;
            got = 1'b0;
            for (int t = 0; t < 20 && !got; t++) begin
                step();
                got = ready;
            end
            check("acc_ready_seen", 32'(got), 32'd1);
            step(); // accept
            step(); // handshake cycle
            valid = 1'b0;
            step();
        end
`ifdef INTER_SLAVE_ACCUM_EN
        exp_acc = 3'd3;
`else
        exp_acc = 3'd6;
`endif
        peek(3'd0, d, d0);
        check("acc_reg0", 32'(d), 32'(exp_acc));
        check("acc_wr_count", 32'(wr_count), 32'd3);

        // Counter wrap on delay-0 instance with valid held: one write per 3 edges
        valid0 = 1'b1; addr_in = 3'd3; value_in = 3'd1;
        repeat (759) step();
        check("wrap_255", 32'(wr_count0), 32'd255);
        repeat (3) step();
        valid0 = 1'b0;
        check("wrap_0", 32'(wr_count0), 32'd0);
        step();
        check("wrap_busy", 32'(busy0), 32'd0);
`ifdef INTER_SLAVE_ACCUM_EN
        exp_wrap = 3'd6; // 254 mod 8
`else
        exp_wrap = 3'd1;
`endif
        peek(3'd3, d, d0);
        check("wrap_reg3", 32'(d0), 32'(exp_wrap));

        // Reset while ready is high aborts the transfer
        valid = 1'b1; addr_in = 3'd4; value_in = 3'd2; rd_addr = 3'd4;
        got = 1'b0;
        for (int t = 0; t < 20 && !got; t++) begin
            step();
            got = ready;
        end
        check("rst_ready_seen", 32'(got), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_wr_count", 32'(wr_count), 32'd0);
        check("rst_reg0", 32'(dut.regs[0]), 32'd0);
        valid = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        check("rst_rd_data", 32'(rd_data), 32'd0);
        check("rst_wr_count_after", 32'(wr_count), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
